ifft_input_buffer: RTL

//   Ping-pong frame buffer directly upstream of the 16-point IFFT core. Collects
//   16 complex 16-bit fixed-point subcarrier samples per frame from the mapper and

---
 rtl/ifft_input_buffer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/ifft_input_buffer.sv
// Ping-pong frame buffer feeding the 16-point IFFT core: fills one bank while the other drains.
// Define IFFT_IN_BITREV_EN to store samples in bit-reversed order for an in-place DIT core.
module ifft_input_buffer #(
    parameter int DATA_W = 16,
    parameter int N_PTS  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              in_sof_i,
    input  logic [DATA_W-1:0] in_re_i,
    input  logic [DATA_W-1:0] in_im_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_re_o,
    output logic [DATA_W-1:0] out_im_o,
    output logic [3:0]        out_idx_o,
    output logic              out_last_o,
    output logic              err_resync_o
);

    localparam int SW = 2 * DATA_W;
    localparam logic [3:0] LAST = 4'(N_PTS - 1);

    typedef struct packed {
        logic [DATA_W-1:0] re;
        logic [DATA_W-1:0] im;
    } sample_t;

    sample_t         mem_q [2][N_PTS];
    logic            wr_bank_q, wr_bank_d;
    logic            rd_bank_q, rd_bank_d;
    logic [3:0]      wr_cnt_q, wr_cnt_d;
    logic [3:0]      rd_cnt_q, rd_cnt_d;
    logic [1:0]      full_q, full_d;
    logic            err_q, err_d;

    logic            wr_acc, rd_xfer, resync;
    logic [3:0]      wr_addr;
    sample_t         rd_smp;

    function automatic logic [3:0] addr(input logic [3:0] k);
`ifdef IFFT_IN_BITREV_EN
        return {k[0], k[1], k[2], k[3]};
`else
        return k;
`endif
    endfunction

    assign in_ready_o  = !rst_i && !full_q[wr_bank_q];
    assign wr_acc      = in_valid_i && in_ready_o;
    assign out_valid_o = full_q[rd_bank_q];
    assign rd_xfer     = out_valid_o && out_ready_i;
    // An early start-of-frame restarts the current bank at index 0.
    assign resync      = wr_acc && in_sof_i && (wr_cnt_q != 4'd0);
    assign wr_addr     = resync ? addr(4'd0) : addr(wr_cnt_q);

    always_comb begin
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        full_d    = full_q;
        err_d     = resync;

        if (wr_acc) begin
            if (resync) begin
                wr_cnt_d = 4'd1;
            end else if (wr_cnt_q == LAST) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
                wr_cnt_d          = 4'd0;
            end else begin
                wr_cnt_d = wr_cnt_q + 4'd1;
            end
        end

        // Write and read always target different banks, so both full updates can coexist.
        if (rd_xfer) begin
            if (rd_cnt_q == LAST) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
                rd_cnt_d          = 4'd0;
            end else begin
                rd_cnt_d = rd_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_cnt_q  <= 4'd0;
            rd_cnt_q  <= 4'd0;
            full_q    <= 2'b00;
            err_q     <= 1'b0;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            full_q    <= full_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_acc)
            mem_q[wr_bank_q][wr_addr] <= sample_t'({in_re_i, in_im_i});
    end

    assign rd_smp       = mem_q[rd_bank_q][rd_cnt_q];
    assign out_re_o     = rd_smp.re;
    assign out_im_o     = rd_smp.im;
    assign out_idx_o    = rd_cnt_q;
    assign out_last_o   = (rd_cnt_q == LAST);
    assign err_resync_o = err_q;

    logic [SW-1:0] unused_w;
    assign unused_w = rd_smp;

endmodule
